imm_extend_pipe: RTL and testbench

- Parametrised, registered successor to the 5-to-32 zero-extension block: widens an IN_WIDTH immediate to OUT_WIDTH bits in one of four modes (zero, sign, upper-placement, sign-and-shift).
- Sits between decode and the datapath operand muxes in the pipelined processor variant.
- Uses valid/ready handshakes on both sides, with a 2-entry (output register + skid register) buffer so backpressure never drops or reorders data.

---
 rtl/imm_extend_pipe.sv | 127 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (zero/sign/upper/sign-shift) with a 2-entry output+skid buffer; 1-cycle latency.
// Backpressure via InReady (skid empty); optional transfer counter under IMM_EXTEND_PIPE_XFER_COUNT_EN.
module imm_extend_pipe #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT       = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [IN_WIDTH-1:0]    InData,
    input  logic [1:0]             InMode,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [OUT_WIDTH-1:0]   OutData,
    output logic                   OutValid,
    input  logic                   OutReady
`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] XferCount
`endif
);

    localparam int PAD = OUT_WIDTH - IN_WIDTH;

    logic                 out_vld_q, out_vld_d;
    logic [OUT_WIDTH-1:0] out_dat_q, out_dat_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [OUT_WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic                 in_rdy_q, in_rdy_d;

    logic                 in_acc;
    logic                 out_xfer;
    logic [OUT_WIDTH-1:0] zext_w;
    logic [OUT_WIDTH-1:0] sext_w;
    logic [OUT_WIDTH-1:0] ext_w;

    // The extended result is computed once, at accept time, so buffered entries are final values.
    always_comb begin
        zext_w = {{PAD{1'b0}}, InData};
        sext_w = {{PAD{InData[IN_WIDTH-1]}}, InData};
        case (InMode)
            2'd0:    ext_w = zext_w;
            2'd1:    ext_w = sext_w;
            2'd2:    ext_w = zext_w << PAD;
            default: ext_w = sext_w << SHIFT;
        endcase
    end

    assign in_acc   = InValid && in_rdy_q;
    assign out_xfer = out_vld_q && OutReady;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (out_xfer) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
                if (in_acc) begin
                    skid_vld_d = 1'b1;
                    skid_dat_d = ext_w;
                end
            end else if (in_acc) begin
                out_vld_d = 1'b1;
                out_dat_d = ext_w;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_acc) begin
            if (!out_vld_q) begin
                out_vld_d = 1'b1;
                out_dat_d = ext_w;
            end else begin
                skid_vld_d = 1'b1;
                skid_dat_d = ext_w;
            end
        end
        // Registered ready: a full skid blocks upstream from the following cycle.
        in_rdy_d = !skid_vld_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b1;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign InReady  = in_rdy_q;
    assign OutData  = out_dat_q;
    assign OutValid = out_vld_q;

`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
    logic [COUNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_xfer) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign XferCount = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed steps plus random traffic against a capacity-2 FIFO reference.
module tb_imm_extend_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] InData;
    logic [1:0]  InMode;
    logic        InValid;
    logic        InReady;
    logic [31:0] OutData;
    logic        OutValid;
    logic        OutReady;
`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
    logic [15:0] XferCount;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    int model_xfers = 0;
    int stream_xfers;

    imm_extend_pipe dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InData   (InData),
        .InMode   (InMode),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady)
`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
        ,
        .XferCount(XferCount)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
        longint u;
        longint s;
        u = longint'(d);
        s = (u >= 32768) ? u - 65536 : u;
        case (m)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: verify DUT against the model before the edge, then apply the edge to the model.
    task automatic cycle();
        bit acc;
        bit xfer;
        @(negedge Clk);
        acc  = 1'b0;
        xfer = 1'b0;
        if (!Reset) begin
            check("out_valid", 32'(OutValid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(InReady), 32'(exp_q.size() < 2));
            if (exp_q.size() != 0) check("out_data_head", OutData, exp_q[0]);
`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
            check("xfer_count", 32'(XferCount), 32'(model_xfers % 65536));
`endif
            acc  = InValid && (exp_q.size() < 2);
            xfer = OutReady && (exp_q.size() != 0);
        end
        @(posedge Clk);
        if (Reset) begin
            exp_q.delete();
            model_xfers = 0;
        end else begin
            if (xfer) begin
                void'(exp_q.pop_front());
                model_xfers++;
            end
            if (acc) exp_q.push_back(model_ext(InData, InMode));
        end
        #1;
    endtask

    task automatic one_shot(input logic [15:0] d, input logic [1:0] m, input logic [31:0] exp, input string tag);
        InData  = d;
        InMode  = m;
        InValid = 1'b1;
        cycle();
        InValid = 1'b0;
        check({tag, "_vld"}, 32'(OutValid), 32'd1);
        check(tag, OutData, exp);
        cycle();
    endtask

    initial begin
        Reset    = 1'b1;
        InData   = '0;
        InMode   = '0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_out_data", OutData, 32'd0);
        check("rst_in_ready", 32'(InReady), 32'd1);
`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
        check("rst_xfer_count", 32'(XferCount), 32'd0);
`endif

        one_shot(16'h8001, 2'd0, 32'h0000_8001, "zero_8001");
        one_shot(16'h8001, 2'd1, 32'hFFFF_8001, "sign_8001");
        one_shot(16'h7FFF, 2'd1, 32'h0000_7FFF, "sign_7fff");
        one_shot(16'h1234, 2'd2, 32'h1234_0000, "upper_1234");
        one_shot(16'hFFFF, 2'd3, 32'hFFFF_FFFC, "sshift_ffff");
        one_shot(16'h0001, 2'd3, 32'h0000_0004, "sshift_0001");

        OutReady = 1'b0;
        InMode   = 2'd0;
        InValid  = 1'b1;
        InData   = 16'h0001;
        cycle();
        InData = 16'h0002;
        cycle();
        check("bp_ready_low", 32'(InReady), 32'd0);
        InData = 16'h0003;
        cycle();
        cycle();
        check("bp_hold_a", OutData, 32'h1);
        check("bp_c_blocked", 32'(InReady), 32'd0);
        OutReady = 1'b1;
        cycle();
        check("bp_out_b", OutData, 32'h2);
        check("bp_ready_back", 32'(InReady), 32'd1);
        cycle();
        InValid = 1'b0;
        check("bp_out_c", OutData, 32'h3);
        cycle();
        check("bp_drained", 32'(OutValid), 32'd0);

        stream_xfers = model_xfers;
        for (int i = 0; i < 8; i++) begin
            InValid = 1'b1;
            InData  = 16'(16'hA000 + i);
            InMode  = 2'(i);
            cycle();
            check("stream_ready", 32'(InReady), 32'd1);
        end
        InValid = 1'b0;
        cycle();
        check("stream_count", 32'(model_xfers - stream_xfers), 32'd8);
        check("stream_empty", 32'(OutValid), 32'd0);

        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 16'h0011;
        cycle();
        InData = 16'h0022;
        cycle();
        InValid = 1'b0;
        check("pre_rst_full", 32'(InReady), 32'd0);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        check("mid_rst_vld", 32'(OutValid), 32'd0);
        check("mid_rst_data", OutData, 32'd0);
        check("mid_rst_ready", 32'(InReady), 32'd1);
`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
        check("mid_rst_count", 32'(XferCount), 32'd0);
`endif
        OutReady = 1'b1;
        one_shot(16'hFF80, 2'd1, 32'hFFFF_FF80, "post_rst");

        for (int i = 0; i < 400; i++) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = ($urandom_range(0, 3) != 0);
            InData   = 16'($urandom);
            InMode   = 2'($urandom_range(0, 3));
            cycle();
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        cycle();
        cycle();
        cycle();
        check("final_empty", 32'(OutValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
